// File: rtl/conv_window_gen_pkg.sv
// Shared defaults and window indexing helper for the sliding-window generator.
package conv_window_gen_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_K      = 3;

  // Bit offset of element (r,c) inside the flattened window bus.
  function automatic int win_idx(input int r, input int c, input int k, input int w);
    return (r * k + c) * w;
  endfunction

endpackage

// File: rtl/conv_window_gen_line_delay.sv
// Enabled RAM-based delay line: returns the word written DEPTH enabled cycles earlier.
module line_delay_en #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     ptr_d;

  // Read-before-write on one shared pointer gives exactly DEPTH enabled cycles of delay.
  assign dout_o = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator: line delays feed a KxK register array,
// raster counters gate out_valid so no emitted window straddles a row or frame edge.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = DEFAULT_K
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     pixel_in,
  output logic                  out_valid,
  output logic [K*K*DATA_W-1:0] window,
  output logic                  frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

  // Handshake: a pixel is taken on every rising edge with in_valid=1 (never stalled);
  // out_valid/frame_done are single-cycle qualifiers registered from that edge.
  logic accept;
  assign accept = in_valid;

  logic [DATA_W-1:0] tap  [K-1];
  logic [DATA_W-1:0] ldin [K-1];

  for (genvar i = 0; i < K - 1; i++) begin : g_line
    if (i == 0) begin : g_first
      assign ldin[i] = pixel_in;
    end else begin : g_chain
      assign ldin[i] = tap[i-1];
    end

    line_delay_en #(
      .DATA_W(DATA_W),
      .DEPTH (IMG_W)
    ) u_delay (
      .clk_i (clock),
      .rst_ni(reset),
      .en_i  (accept),
      .din_i (ldin[i]),
      .dout_o(tap[i])
    );
  end

  logic [DATA_W-1:0] win_q [K][K];
  logic [DATA_W-1:0] win_d [K][K];
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  always_comb begin
    win_d   = win_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      // Newest column: bottom row is live pixel, older rows come from deeper delays.
      win_d[K-1][K-1] = pixel_in;
      for (int i = 1; i < K; i++) begin
        win_d[K-1-i][K-1] = tap[i-1];
      end

      valid_d = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
      done_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      win_q   <= win_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_flat_r
    for (genvar c = 0; c < K; c++) begin : g_flat_c
      assign window[win_idx(r, c, K, DATA_W) +: DATA_W] = win_q[r][c];
    end
  end

  assign out_valid  = valid_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen with a raster image model and expected-window queue.
module tb_conv_window_gen;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int K      = 3;
  localparam int WW     = K * K * DATA_W;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] pixel_in = '0;
  logic              out_valid;
  logic [WW-1:0]     window;
  logic              frame_done;

  conv_window_gen #(
    .DATA_W(DATA_W),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .pixel_in  (pixel_in),
    .out_valid (out_valid),
    .window    (window),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int ov_cnt    = 0;
  int fd_cnt    = 0;

  logic [WW:0]       exp_q [$];
  logic [WW:0]       exp_v;
  logic [DATA_W-1:0] img [IMG_H][IMG_W];
  int                mrow = 0;
  int                mcol = 0;
  logic              acc_prev = 1'b0;
  logic              gap_mode = 1'b0;
  logic [WW-1:0]     last_win = '0;

  // Reference model: windows are cut directly from a raster image, keyed by pixel position.
  task automatic model_accept(input logic [DATA_W-1:0] p);
    logic [WW-1:0] w;
    logic          fd;
    img[mrow][mcol] = p;
    if (mrow >= K - 1 && mcol >= K - 1) begin
      w = '0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          w[(r*K+c)*DATA_W +: DATA_W] = img[mrow-K+1+r][mcol-K+1+c];
        end
      end
      fd = (mrow == IMG_H - 1) && (mcol == IMG_W - 1);
      exp_q.push_back({fd, w});
    end
    if (mcol == IMG_W - 1) begin
      mcol = 0;
      mrow = (mrow == IMG_H - 1) ? 0 : mrow + 1;
    end else begin
      mcol = mcol + 1;
    end
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] p);
    @(posedge clock);
    #1;
    in_valid = v;
    pixel_in = p;
    if (v) model_accept(p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, DATA_W'($urandom_range(0, 255)));
  endtask

  initial begin
    forever begin
      @(posedge clock);
      acc_prev = in_valid && reset;
    end
  end

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        if (out_valid) begin
          ov_cnt++;
          total_cnt++;
          if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: out_valid=1 window=%h, no window required", window);
          end else begin
            exp_v = exp_q.pop_front();
            if ({frame_done, window} !== exp_v)
              $display("FAIL sb_window: got fd=%b win=%h, required fd=%b win=%h",
                       frame_done, window, exp_v[WW], exp_v[WW-1:0]);
            else
              pass_cnt++;
          end
        end else if (frame_done) begin
          total_cnt++;
          $display("FAIL sb_fd_alone: frame_done=1 with out_valid=0, required 0");
        end
        if (frame_done) fd_cnt++;
        if (gap_mode && !acc_prev) begin
          total_cnt++;
          if (out_valid !== 1'b0 || window !== last_win)
            $display("FAIL gap_hold: out_valid=%b win=%h, required 0 and %h", out_valid, window, last_win);
          else
            pass_cnt++;
        end
        last_win = window;
      end
    end
  end

  task automatic check_counts(input string name, input int ov0, input int fd0,
                              input int ov_req, input int fd_req);
    total_cnt++;
    if (ov_cnt - ov0 !== ov_req)
      $display("FAIL %s_ov_count: got %0d, required %0d", name, ov_cnt - ov0, ov_req);
    else pass_cnt++;
    total_cnt++;
    if (fd_cnt - fd0 !== fd_req)
      $display("FAIL %s_fd_count: got %0d, required %0d", name, fd_cnt - fd0, fd_req);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() !== 0)
      $display("FAIL %s_queue: %0d windows still pending, required 0", name, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      pixel_in = DATA_W'($urandom_range(0, 255));
      total_cnt++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0 || window !== '0)
        $display("FAIL reset_state: ov=%b fd=%b win=%h, required 0 0 0", out_valid, frame_done, window);
      else pass_cnt++;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    mrow     = 0;
    mcol     = 0;
  endtask

  task automatic test_basic_window();
    int ov0 = ov_cnt;
    int fd0 = fd_cnt;
    for (int p = 0; p < 16; p++) drive(1'b1, DATA_W'(p));
    idle(3);
    check_counts("basic", ov0, fd0, 4, 1);
  endtask

  task automatic test_gapped();
    int ov0 = ov_cnt;
    int fd0 = fd_cnt;
    gap_mode = 1'b1;
    for (int p = 0; p < 16; p++) begin
      drive(1'b1, DATA_W'(p));
      idle(2);
    end
    idle(1);
    gap_mode = 1'b0;
    check_counts("gapped", ov0, fd0, 4, 1);
  endtask

  task automatic test_back_to_back();
    int ov0 = ov_cnt;
    int fd0 = fd_cnt;
    for (int p = 0; p < 32; p++) drive(1'b1, DATA_W'(p));
    idle(3);
    check_counts("b2b", ov0, fd0, 8, 2);
  endtask

  task automatic test_reset_mid_frame();
    int ov0;
    int fd0;
    for (int p = 0; p < 7; p++) drive(1'b1, DATA_W'(p));
    @(posedge clock);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    mrow     = 0;
    mcol     = 0;
    @(negedge clock);
    total_cnt++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL midreset_outputs: ov=%b fd=%b, required 0 0", out_valid, frame_done);
    else pass_cnt++;
    @(posedge clock);
    #1;
    reset = 1'b1;
    ov0 = ov_cnt;
    fd0 = fd_cnt;
    for (int p = 0; p < 16; p++) drive(1'b1, DATA_W'(p));
    idle(3);
    check_counts("midreset", ov0, fd0, 4, 1);
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_gapped();
    test_back_to_back();
    test_reset_mid_frame();
    idle(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
